// File: rtl/bus_arbiter.sv
// Two-requester (CPU6 / DMA) memory bus arbiter with fixed wait-state sequencing.
// Define BUS_ARB_RR_EN to resolve ties round-robin instead of CPU-first priority.
module bus_arbiter #(
    parameter int unsigned WAIT_STATES   = 1,
    parameter int unsigned DMA_MAX_BURST = 4
) (
    input  logic        clock,
    input  logic        reset_,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_wdata,
    output logic        cpu_grant,
    output logic        cpu_done,
    input  logic        dma_req,
    input  logic        dma_we,
    input  logic [15:0] dma_addr,
    input  logic [7:0]  dma_wdata,
    output logic        dma_grant,
    output logic        dma_done,
    output logic [7:0]  rd_data,
    output logic        mem_en,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_wdata,
    input  logic [7:0]  mem_rdata
);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_e;
    typedef enum logic {OWN_C, OWN_D} owner_e;

    localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);
    localparam logic [3:0] BURST_MAX = 4'(DMA_MAX_BURST);

    state_e      state_q, state_d;
    owner_e      owner_q, owner_d;
    logic [3:0]  burst_q, burst_d;
    logic [3:0]  wait_q, wait_d;
    logic        we_q, we_d;
    logic [15:0] addr_q, addr_d;
    logic [7:0]  wdata_q, wdata_d;
    logic [7:0]  rd_q, rd_d;
    logic        cpu_grant_q, cpu_grant_d;
    logic        dma_grant_q, dma_grant_d;
    logic        cpu_done_q, cpu_done_d;
    logic        dma_done_q, dma_done_d;
    logic        mem_en_q, mem_en_d;
    logic        mem_we_q, mem_we_d;

    logic   hold;
    owner_e tie_win;
    owner_e win;

    // owner_q doubles as last_owner: it keeps the previous owner while IDLE.
    always_comb begin
        hold = (owner_q == OWN_D) && dma_req && (burst_q < BURST_MAX);
`ifdef BUS_ARB_RR_EN
        tie_win = (owner_q == OWN_C) ? OWN_D : OWN_C;
`else
        tie_win = OWN_C;
`endif
        if (hold)
            win = OWN_D;
        else if (cpu_req && dma_req)
            win = tie_win;
        else if (cpu_req)
            win = OWN_C;
        else
            win = OWN_D;
    end

    always_ff @(posedge clock or negedge reset_) begin
        if (!reset_) begin
            state_q     <= IDLE;
            owner_q     <= OWN_C;
            burst_q     <= '0;
            wait_q      <= '0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rd_q        <= '0;
            cpu_grant_q <= 1'b0;
            dma_grant_q <= 1'b0;
            cpu_done_q  <= 1'b0;
            dma_done_q  <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            burst_q     <= burst_d;
            wait_q      <= wait_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rd_q        <= rd_d;
            cpu_grant_q <= cpu_grant_d;
            dma_grant_q <= dma_grant_d;
            cpu_done_q  <= cpu_done_d;
            dma_done_q  <= dma_done_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
        end
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        burst_d = burst_q;
        wait_d  = wait_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rd_d    = rd_q;
        unique case (state_q)
            IDLE: begin
                if (cpu_req || dma_req) begin
                    owner_d = win;
                    wait_d  = WAIT_INIT;
                    state_d = ACCESS;
                    if (win == OWN_C) begin
                        we_d    = cpu_we;
                        addr_d  = cpu_addr;
                        wdata_d = cpu_wdata;
                        burst_d = '0;
                    end else begin
                        we_d    = dma_we;
                        addr_d  = dma_addr;
                        wdata_d = dma_wdata;
                        if (!cpu_req)
                            burst_d = '0;
                        else if (burst_q != 4'hF)
                            burst_d = burst_q + 4'd1;
                    end
                end
            end
            ACCESS: begin
                if (wait_q == '0) begin
                    state_d = DONE;
                    if (!we_q)
                        rd_d = mem_rdata;
                end else begin
                    wait_d = wait_q - 4'd1;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they register in step with it.
    always_comb begin
        cpu_grant_d = (state_d != IDLE) && (owner_d == OWN_C);
        dma_grant_d = (state_d != IDLE) && (owner_d == OWN_D);
        cpu_done_d  = (state_d == DONE) && (owner_d == OWN_C);
        dma_done_d  = (state_d == DONE) && (owner_d == OWN_D);
        mem_en_d    = (state_d == ACCESS);
        mem_we_d    = (state_d == ACCESS) && we_d;
    end

    assign cpu_grant = cpu_grant_q;
    assign dma_grant = dma_grant_q;
    assign cpu_done  = cpu_done_q;
    assign dma_done  = dma_done_q;
    assign rd_data   = rd_q;
    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Scoreboard bench for bus_arbiter: two instances (WAIT_STATES=1/BURST=4 and WAIT_STATES=0/BURST=1).
module tb_bus_arbiter;

    localparam int unsigned WA = 1;
    localparam int unsigned WB = 0;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        rst[2];
    logic        c_req[2], c_we[2], d_req[2], d_we[2];
    logic [15:0] c_addr[2], d_addr[2];
    logic [7:0]  c_wd[2], d_wd[2];
    logic        c_gnt[2], c_done[2], d_gnt[2], d_done[2], men[2], mwe[2];
    logic [7:0]  rd[2], mwd[2], mrd[2];
    logic [15:0] maddr[2];

    int checks = 0;
    int failures = 0;
    int acc[2];

    typedef struct {
        int          dut;
        bit          dma;
        bit          we;
        logic [15:0] addr;
        logic [7:0]  wd;
    } exp_t;
    exp_t qo[$];

    function automatic logic [7:0] mem_model(logic [15:0] a);
        return a[7:0] ^ a[15:8] ^ 8'hA4;
    endfunction

    assign mrd[0] = mem_model(maddr[0]);
    assign mrd[1] = mem_model(maddr[1]);

    bus_arbiter #(.WAIT_STATES(WA), .DMA_MAX_BURST(4)) u_a (
        .clock(clock), .reset_(rst[0]),
        .cpu_req(c_req[0]), .cpu_we(c_we[0]), .cpu_addr(c_addr[0]), .cpu_wdata(c_wd[0]),
        .cpu_grant(c_gnt[0]), .cpu_done(c_done[0]),
        .dma_req(d_req[0]), .dma_we(d_we[0]), .dma_addr(d_addr[0]), .dma_wdata(d_wd[0]),
        .dma_grant(d_gnt[0]), .dma_done(d_done[0]),
        .rd_data(rd[0]), .mem_en(men[0]), .mem_we(mwe[0]), .mem_addr(maddr[0]),
        .mem_wdata(mwd[0]), .mem_rdata(mrd[0])
    );

    bus_arbiter #(.WAIT_STATES(WB), .DMA_MAX_BURST(1)) u_b (
        .clock(clock), .reset_(rst[1]),
        .cpu_req(c_req[1]), .cpu_we(c_we[1]), .cpu_addr(c_addr[1]), .cpu_wdata(c_wd[1]),
        .cpu_grant(c_gnt[1]), .cpu_done(c_done[1]),
        .dma_req(d_req[1]), .dma_we(d_we[1]), .dma_addr(d_addr[1]), .dma_wdata(d_wd[1]),
        .dma_grant(d_gnt[1]), .dma_done(d_done[1]),
        .rd_data(rd[1]), .mem_en(men[1]), .mem_we(mwe[1]), .mem_addr(maddr[1]),
        .mem_wdata(mwd[1]), .mem_rdata(mrd[1])
    );

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic int wait_of(int d);
        return (d == 0) ? int'(WA) : int'(WB);
    endfunction

    task automatic push(int d, bit dma, bit we, logic [15:0] a, logic [7:0] wd);
        exp_t e;
        e.dut = d; e.dma = dma; e.we = we; e.addr = a; e.wd = wd;
        qo.push_back(e);
    endtask

    // Drive one transfer, hold it until done, release on the edge ending the done cycle.
    task automatic xfer(int d, bit dma, bit we, logic [15:0] a, logic [7:0] wd, int lat);
        int n;
        logic seen;
        if (dma) begin
            d_we[d] = we; d_addr[d] = a; d_wd[d] = wd; d_req[d] = 1'b1;
        end else begin
            c_we[d] = we; c_addr[d] = a; c_wd[d] = wd; c_req[d] = 1'b1;
        end
        n = 0;
        seen = 1'b0;
        while (!seen && n < 60) begin
            @(posedge clock); #1;
            n++;
            seen = dma ? d_done[d] : c_done[d];
        end
        if (!seen) begin
            checks++;
            failures++;
            $display("FAIL timeout dut=%0d dma=%0d addr=%0h actual=no_done required=done", d, dma, a);
        end else if (lat != 0) begin
            chk("latency", 64'(n), 64'(lat));
        end
        @(posedge clock); #1;
        if (dma) d_req[d] = 1'b0;
        else     c_req[d] = 1'b0;
    endtask

    always @(negedge clock) begin
        for (int d = 0; d < 2; d++) begin
            if (!rst[d]) begin
                acc[d] = 0;
            end else begin
                chk("grant_exclusive", 64'(c_gnt[d] & d_gnt[d]), 64'd0);
                if (men[d]) begin
                    acc[d]++;
                    if (qo.size() > 0 && qo[0].dut == d) begin
                        chk("mem_addr", 64'(maddr[d]), 64'(qo[0].addr));
                        chk("mem_we", 64'(mwe[d]), 64'(qo[0].we));
                        if (qo[0].we) chk("mem_wdata", 64'(mwd[d]), 64'(qo[0].wd));
                    end
                end
                if (c_done[d] || d_done[d]) begin
                    if (qo.size() == 0) begin
                        chk("unexpected_done", 64'({c_done[d], d_done[d]}), 64'd0);
                    end else begin
                        exp_t e;
                        e = qo.pop_front();
                        chk("done_dut", 64'(d), 64'(e.dut));
                        chk("done_onehot", 64'(c_done[d] & d_done[d]), 64'd0);
                        chk("done_owner", 64'(d_done[d]), 64'(e.dma));
                        chk("grant_c", 64'(c_gnt[d]), 64'(!e.dma));
                        chk("grant_d", 64'(d_gnt[d]), 64'(e.dma));
                        chk("mem_en_in_done", 64'(men[d]), 64'd0);
                        chk("access_cycles", 64'(acc[d]), 64'(wait_of(d) + 1));
                        if (!e.we) chk("rd_data", 64'(rd[d]), 64'(mem_model(e.addr)));
                    end
                    acc[d] = 0;
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int d = 0; d < 2; d++) begin
            rst[d] = 1'b0; acc[d] = 0;
            c_req[d] = 1'b0; c_we[d] = 1'b0; c_addr[d] = '0; c_wd[d] = '0;
            d_req[d] = 1'b0; d_we[d] = 1'b0; d_addr[d] = '0; d_wd[d] = '0;
        end
        repeat (3) @(posedge clock);
        #1;
        for (int d = 0; d < 2; d++)
            chk("reset_outputs",
                64'({c_gnt[d], c_done[d], d_gnt[d], d_done[d], men[d], mwe[d], rd[d], mwd[d], maddr[d]}),
                64'd0);
        @(negedge clock);
        rst[0] = 1'b1;
        rst[1] = 1'b1;
        @(posedge clock); #1;

        // C read 0100 with WAIT_STATES=1
        push(0, 1'b0, 1'b0, 16'h0100, 8'h00);
        xfer(0, 1'b0, 1'b0, 16'h0100, 8'h00, WA + 2);
        chk("t1_rd_data", 64'(rd[0]), 64'h A5);

        // simultaneous C and D requests
`ifdef BUS_ARB_RR_EN
        push(0, 1'b1, 1'b0, 16'h4321, 8'h00);
        push(0, 1'b0, 1'b1, 16'h0010, 8'h11);
`else
        push(0, 1'b0, 1'b1, 16'h0010, 8'h11);
        push(0, 1'b1, 1'b0, 16'h4321, 8'h00);
`endif
        fork
            xfer(0, 1'b0, 1'b1, 16'h0010, 8'h11, 0);
            xfer(0, 1'b1, 1'b0, 16'h4321, 8'h00, 0);
        join
        chk("t3_rd_data", 64'(rd[0]), 64'h C6);

        // D write 8000 / 3C; read data must hold through a write
        push(0, 1'b1, 1'b1, 16'h8000, 8'h3C);
        xfer(0, 1'b1, 1'b1, 16'h8000, 8'h3C, WA + 2);
        chk("t2_rd_hold", 64'(rd[0]), 64'h C6);

        // D streams 6 writes; C arrives during D #1 and gets in after 4 burst-held transfers
        for (int i = 0; i < 5; i++) push(0, 1'b1, 1'b1, 16'(16'h9000 + i), 8'(i + 1));
        push(0, 1'b0, 1'b0, 16'h0300, 8'h00);
        push(0, 1'b1, 1'b1, 16'h9005, 8'h06);
        fork
            begin
                for (int i = 0; i < 6; i++) xfer(0, 1'b1, 1'b1, 16'(16'h9000 + i), 8'(i + 1), 0);
            end
            begin
                int n;
                n = 0;
                while (!d_gnt[0] && n < 20) begin
                    @(posedge clock); #1;
                    n++;
                end
                xfer(0, 1'b0, 1'b0, 16'h0300, 8'h00, 0);
            end
        join

        // reset during the 2nd ACCESS cycle aborts the transfer
        c_we[0] = 1'b0; c_addr[0] = 16'h0200; c_req[0] = 1'b1;
        @(posedge clock); #1;
        chk("t6_mem_en_access", 64'(men[0]), 64'd1);
        @(posedge clock); #1;
        rst[0] = 1'b0;
        #1;
        chk("t6_abort", 64'({men[0], c_gnt[0], c_done[0]}), 64'd0);
        c_req[0] = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        rst[0] = 1'b1;
        repeat (4) @(posedge clock);
        #1;
        chk("t6_idle_after", 64'({men[0], c_gnt[0], d_gnt[0]}), 64'd0);
        push(0, 1'b0, 1'b1, 16'h0404, 8'h77);
        xfer(0, 1'b0, 1'b1, 16'h0404, 8'h77, WA + 2);

        // WAIT_STATES=0 C read
        push(1, 1'b0, 1'b0, 16'h1234, 8'h00);
        xfer(1, 1'b0, 1'b0, 16'h1234, 8'h00, WB + 2);
        chk("t7_rd_data", 64'(rd[1]), 64'h82);

        // both held, DMA_MAX_BURST=1
`ifdef BUS_ARB_RR_EN
        push(1, 1'b1, 1'b1, 16'h3000, 8'hAA);
        push(1, 1'b0, 1'b0, 16'h2000, 8'h00);
        push(1, 1'b1, 1'b1, 16'h3001, 8'hBB);
        push(1, 1'b0, 1'b0, 16'h2001, 8'h00);
`else
        push(1, 1'b0, 1'b0, 16'h2000, 8'h00);
        push(1, 1'b0, 1'b0, 16'h2001, 8'h00);
        push(1, 1'b1, 1'b1, 16'h3000, 8'hAA);
        push(1, 1'b1, 1'b1, 16'h3001, 8'hBB);
`endif
        fork
            begin
                xfer(1, 1'b0, 1'b0, 16'h2000, 8'h00, 0);
                xfer(1, 1'b0, 1'b0, 16'h2001, 8'h00, 0);
            end
            begin
                xfer(1, 1'b1, 1'b1, 16'h3000, 8'hAA, 0);
                xfer(1, 1'b1, 1'b1, 16'h3001, 8'hBB, 0);
            end
        join

        repeat (3) @(posedge clock);
        #1;
        chk("queue_drained", 64'(qo.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
